// File: rtl/fir_pkg.sv
// Types and default sizing shared by the FIR datapath and its coefficient loader.
package fir_pkg;

    localparam int DEFAULT_TAP_COUNT  = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } loader_state_t;

endpackage

// File: rtl/coeff_shadow_bank.sv
// Shadow coefficient register file: sequential writes through an internal pointer,
// full-bank parallel read for an atomic commit into the active bank.
module coeff_shadow_bank #(
    parameter int TAP_COUNT  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 ptr_clr,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic                                 last_wr,
    output logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] bank
);

    localparam int PTR_W = $clog2(TAP_COUNT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TAP_COUNT - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] wr_addr;

    // A clear in the same cycle as a write makes that word coefficient 0.
    assign wr_addr = ptr_clr ? '0 : ptr;
    assign last_wr = wr_en && (wr_addr == LAST_IDX);

    // NOTE: this register file is reset on purpose so a reset mid-load leaves no stale words;
    // large RAM-style arrays normally stay unreset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr  <= '0;
            bank <= '0;
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
            ptr           <= last_wr ? '0 : wr_addr + 1'b1;
        end else if (ptr_clr) begin
            ptr <= '0;
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: streams taps into a shadow bank and commits the whole bank
// to the FIR only while the FIR is idle, so no dot product mixes old and new taps.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int TAP_COUNT  = DEFAULT_TAP_COUNT,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 cfg_start,
    input  logic                                 cfg_wr_en,
    input  logic [DATA_WIDTH-1:0]                cfg_data,
    output logic                                 cfg_ready,
    input  logic                                 fir_idle,
    output logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] taps,
    output logic                                 taps_valid,
    output logic                                 swap_pulse,
    output logic                                 load_error
);

    loader_state_t                        state;
    logic                                 accept;
    logic                                 bank_wr_en;
    logic                                 bank_clr;
    logic                                 last_wr;
    logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] shadow;

    // Words are taken in LOAD, or in IDLE when they arrive together with a start.
    assign accept     = (state == LOAD) || ((state == IDLE) && cfg_start);
    assign bank_wr_en = accept && cfg_wr_en;
    assign bank_clr   = cfg_start && (state != PENDING);
    assign cfg_ready  = (state != PENDING);

    coeff_shadow_bank #(
        .TAP_COUNT (TAP_COUNT),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shadow (
        .clock  (clock),
        .reset_n(reset_n),
        .ptr_clr(bank_clr),
        .wr_en  (bank_wr_en),
        .wr_data(cfg_data),
        .last_wr(last_wr),
        .bank   (shadow)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            taps       <= '0;
            taps_valid <= 1'b0;
            swap_pulse <= 1'b0;
            load_error <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state      <= LOAD;
                        load_error <= 1'b0;
                    end else if (cfg_wr_en) begin
                        load_error <= 1'b1;
                    end
                end
                LOAD: begin
                    if (last_wr) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (cfg_wr_en || cfg_start) begin
                        load_error <= 1'b1;
                    end
                    if (fir_idle) begin
                        taps       <= shadow;
                        taps_valid <= 1'b1;
                        swap_pulse <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: table-driven loads with a commit scoreboard,
// plus hand-written abort, error, reset and two-tap sequences.
module tb_fir_coeff_loader;

    typedef logic [7:0][31:0] bank8_t;

    typedef struct {
        bank8_t      words;
        int          stall;
        logic [255:0] exp_taps;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_wr_en, fir_idle;
    logic [31:0] cfg_data;
    logic        cfg_ready, taps_valid, swap_pulse, load_error;
    bank8_t      taps;

    logic             c2_start, c2_wr_en, c2_idle;
    logic [31:0]      c2_data;
    logic             c2_ready, c2_valid, c2_swap, c2_error;
    logic [1:0][31:0] c2_taps;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] exp_q[$];
    logic [255:0] model_taps;
    vec_t         vecs[3];

    always #5 clock = ~clock;

    fir_coeff_loader #(.TAP_COUNT(8), .DATA_WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_start (cfg_start),
        .cfg_wr_en (cfg_wr_en),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .fir_idle  (fir_idle),
        .taps      (taps),
        .taps_valid(taps_valid),
        .swap_pulse(swap_pulse),
        .load_error(load_error)
    );

    fir_coeff_loader #(.TAP_COUNT(2), .DATA_WIDTH(32)) dut2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_start (c2_start),
        .cfg_wr_en (c2_wr_en),
        .cfg_data  (c2_data),
        .cfg_ready (c2_ready),
        .fir_idle  (c2_idle),
        .taps      (c2_taps),
        .taps_valid(c2_valid),
        .swap_pulse(c2_swap),
        .load_error(c2_error)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [31:0] w, input logic with_start);
        cfg_start = with_start;
        cfg_wr_en = 1'b1;
        cfg_data  = w;
        tick();
        cfg_start = 1'b0;
        cfg_wr_en = 1'b0;
    endtask

    // Called right after the final write edge; expects the commit on the next edge once idle.
    task automatic expect_commit(input logic [255:0] exp, input int stall);
        for (int s = 0; s < stall; s++) begin
            check("stall_ready_low", 256'(cfg_ready), 256'd0);
            check("stall_taps_hold", taps, model_taps);
            tick();
        end
        fir_idle = 1'b1;
        exp_q.push_back(exp);
        tick();
        check("commit_taps", taps, exp);
        check("commit_swap", 256'(swap_pulse), 256'd1);
        check("commit_valid", 256'(taps_valid), 256'd1);
        model_taps = exp;
        tick();
        check("swap_one_cycle", 256'(swap_pulse), 256'd0);
    endtask

    // Scoreboard: every swap_pulse must match the oldest expected bank.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (swap_pulse) begin
                if (exp_q.size() == 0)
                    check("swap_without_expect", 256'(swap_pulse), 256'd0);
                else
                    check("scoreboard_taps", taps, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            vecs[0].words[k] = 32'(k + 1);
            vecs[1].words[k] = 32'(k + 9);
            vecs[2].words[k] = 32'hA5A5_0000 + 32'(k) * 32'h1111;
        end
        vecs[0].stall    = 0;
        vecs[0].exp_taps = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        vecs[1].stall    = 20;
        vecs[1].exp_taps = 256'h00000010_0000000F_0000000E_0000000D_0000000C_0000000B_0000000A_00000009;
        vecs[2].stall    = 3;
        vecs[2].exp_taps = 256'hA5A57777_A5A56666_A5A55555_A5A54444_A5A53333_A5A52222_A5A51111_A5A50000;

        reset_n   = 1'b0;
        cfg_start = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_data  = '0;
        fir_idle  = 1'b1;
        c2_start  = 1'b0;
        c2_wr_en  = 1'b0;
        c2_data   = '0;
        c2_idle   = 1'b1;
        model_taps = '0;
        #12;
        check("rst_taps", taps, 256'd0);
        check("rst_valid", 256'(taps_valid), 256'd0);
        check("rst_swap", 256'(swap_pulse), 256'd0);
        check("rst_error", 256'(load_error), 256'd0);
        check("rst_ready", 256'(cfg_ready), 256'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Table-driven loads, with and without the FIR holding off the commit.
        for (int v = 0; v < 3; v++) begin
            fir_idle  = (vecs[v].stall == 0);
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            for (int k = 0; k < 8; k++) begin
                check("load_ready_high", 256'(cfg_ready), 256'd1);
                write_word(vecs[v].words[k], 1'b0);
            end
            expect_commit(vecs[v].exp_taps, vecs[v].stall);
        end

        // Abort after three words: restart with start+write, stale words must not survive.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) write_word(32'h100 + 32'(k), 1'b0);
        write_word(32'hA, 1'b1);
        check("abort_taps_untouched", taps, model_taps);
        check("abort_error_clear", 256'(load_error), 256'd0);
        for (int k = 0; k < 7; k++) write_word(32'hB + 32'(k), 1'b0);
        expect_commit(256'h00000011_00000010_0000000F_0000000E_0000000D_0000000C_0000000B_0000000A, 0);

        // Protocol violations in IDLE and PENDING.
        cfg_wr_en = 1'b1;
        cfg_data  = 32'hDEAD;
        tick();
        cfg_wr_en = 1'b0;
        check("idle_wr_error", 256'(load_error), 256'd1);
        check("idle_wr_taps", taps, model_taps);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_clears_error", 256'(load_error), 256'd0);
        fir_idle = 1'b0;
        for (int k = 0; k < 8; k++) write_word(32'h21 + 32'(k), 1'b0);
        write_word(32'hBAD, 1'b0);
        check("pending_wr_error", 256'(load_error), 256'd1);
        check("pending_wr_taps", taps, model_taps);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("pending_start_error", 256'(load_error), 256'd1);
        expect_commit(256'h00000028_00000027_00000026_00000025_00000024_00000023_00000022_00000021, 0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("restart_clears_error", 256'(load_error), 256'd0);

        // Asynchronous reset while a load waits in PENDING.
        fir_idle  = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) write_word(32'h55 + 32'(k), 1'b0);
        tick();
        check("pend_before_reset_ready", 256'(cfg_ready), 256'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_taps", taps, 256'd0);
        check("async_rst_valid", 256'(taps_valid), 256'd0);
        check("async_rst_ready", 256'(cfg_ready), 256'd1);
        model_taps = '0;
        fir_idle   = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post_rst_no_swap", 256'(swap_pulse), 256'd0);
            check("post_rst_taps_zero", taps, 256'd0);
        end

        // Two-tap instance: start+write then one write completes the load.
        c2_start = 1'b1;
        c2_wr_en = 1'b1;
        c2_data  = 32'd5;
        tick();
        c2_start = 1'b0;
        c2_data  = 32'd6;
        tick();
        c2_wr_en = 1'b0;
        check("tc2_pending_ready", 256'(c2_ready), 256'd0);
        check("tc2_taps_before", 256'(c2_taps), 256'd0);
        tick();
        check("tc2_taps", 256'(c2_taps), 256'h00000006_00000005);
        check("tc2_swap", 256'(c2_swap), 256'd1);
        check("tc2_valid", 256'(c2_valid), 256'd1);
        check("tc2_error", 256'(c2_error), 256'd0);

        tick();
        check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
